// File: rtl/fd_fetch_stage.sv
// F-stage PC generator and F/D pipeline register. Stall freezes PC and F/D and requests a D/E bubble.
// Optional FD_STALL_STAT_EN adds stall/redirect event counters.
module fd_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             D_redirect,
  input  logic [31:0]      D_target,
  input  logic [31:0]      im_rdata,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      F_pc,
  output logic [31:0]      D_instr,
  output logic [31:0]      D_pc,
  output logic             D_valid,
  output logic             de_bubble
`ifdef FD_STALL_STAT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      redirect_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dpc_q, dpc_d;
  logic        dvld_q, dvld_d;
  logic [31:0] npc;
  logic [31:0] pc_off;

  // Branch delay slot: the instruction at F_pc always enters D, only the PC is redirected.
  always_comb begin
    npc     = D_redirect ? (D_target & ~32'h3) : (pc_q + 32'd4);
    pc_d    = pc_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    dvld_d  = dvld_q;
    if (!stall) begin
      pc_d    = npc;
      instr_d = im_rdata;
      dpc_d   = pc_q;
      dvld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      dpc_q   <= PC_RESET;
      dvld_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
      dvld_q  <= dvld_d;
    end
  end

  // Out-of-range PCs simply wrap within the IM word space.
  always_comb begin
    pc_off  = pc_q - IM_BASE;
    im_addr = IM_AW'(pc_off >> 2);
  end

  assign F_pc      = pc_q;
  assign D_instr   = instr_q;
  assign D_pc      = dpc_q;
  assign D_valid   = dvld_q;
  assign de_bubble = stall & ~reset;

`ifdef FD_STALL_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall)           stall_cnt_d    = stall_cnt_q + 32'd1;
    else if (D_redirect) redirect_cnt_d = redirect_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q    <= 32'h0;
      redirect_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fd_fetch_stage.sv
// Scoreboard bench for fd_fetch_stage: directed and random stall/redirect traffic vs a reference model.
// Counter checks are enabled when FD_STALL_STAT_EN is defined.
module tb_fd_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        D_redirect = 1'b0;
  logic [31:0] D_target = 32'h0;
  logic [31:0] im_rdata;
  logic [11:0] im_addr;
  logic [31:0] F_pc, D_instr, D_pc;
  logic        D_valid, de_bubble;
`ifdef FD_STALL_STAT_EN
  logic [31:0] stall_cnt, redirect_cnt;
`endif

  fd_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .D_redirect(D_redirect),
    .D_target(D_target), .im_rdata(im_rdata), .im_addr(im_addr),
    .F_pc(F_pc), .D_instr(D_instr), .D_pc(D_pc), .D_valid(D_valid),
    .de_bubble(de_bubble)
`ifdef FD_STALL_STAT_EN
    , .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {a, 4'h5, a ^ 12'h9C3, 4'hA};
  endfunction

  assign im_rdata = mem_word(im_addr);

  typedef struct {
    logic [31:0] f, di, dp;
    logic        dv, bub;
    logic [11:0] ia;
    logic [31:0] sc, rc;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model state.
  logic [31:0] m_f, m_di, m_dp, m_sc, m_rc;
  logic        m_dv;

  function automatic logic [11:0] addr_of(input logic [31:0] pc);
    logic [31:0] off;
    off = (pc - 32'h3000) / 4;
    return off[11:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_f = 32'h3000; m_dp = 32'h3000; m_di = 32'h0; m_dv = 1'b0;
    m_sc = 0; m_rc = 0;
  endtask

  // One clock cycle: drive inputs, queue the expected view of this cycle, then advance the model.
  task automatic cycle(input logic s, input logic r, input logic [31:0] t);
    exp_t e;
    stall = s; D_redirect = r; D_target = t;
    e.f = m_f; e.di = m_di; e.dp = m_dp; e.dv = m_dv; e.bub = s;
    e.ia = addr_of(m_f); e.sc = m_sc; e.rc = m_rc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (s) m_sc = m_sc + 1;
    else begin
      if (r) m_rc = m_rc + 1;
      m_di = mem_word(addr_of(m_f));
      m_dp = m_f;
      m_dv = 1'b1;
      m_f  = r ? {t[31:2], 2'b00} : m_f + 32'd4;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_F_pc", F_pc, 32'h3000);
    check("rst_D_pc", D_pc, 32'h3000);
    check("rst_D_instr", D_instr, 32'h0);
    check("rst_D_valid", {31'b0, D_valid}, 32'h0);
    check("rst_de_bubble", {31'b0, de_bubble}, 32'h0);
`ifdef FD_STALL_STAT_EN
    check("rst_stall_cnt", stall_cnt, 32'h0);
    check("rst_redirect_cnt", redirect_cnt, 32'h0);
`endif
  endtask

  // Monitor: one expected record per cycle, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("F_pc", F_pc, e.f);
        check("D_instr", D_instr, e.di);
        check("D_pc", D_pc, e.dp);
        check("D_valid", {31'b0, D_valid}, {31'b0, e.dv});
        check("de_bubble", {31'b0, de_bubble}, {31'b0, e.bub});
        check("im_addr", {20'b0, im_addr}, {20'b0, e.ia});
`ifdef FD_STALL_STAT_EN
        check("stall_cnt", stall_cnt, e.sc);
        check("redirect_cnt", redirect_cnt, e.rc);
`endif
      end
    end
  end

  initial begin
    model_reset();
    stall = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_reset_vals();
    stall = 1'b0;
    #2 reset = 1'b0;

    // Straight line.
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    // Stall 3 cycles, then resume.
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    // Redirect with delay slot kept.
    cycle(1'b0, 1'b1, 32'h3100);
    cycle(1'b0, 1'b0, 32'h0);
    // Stall and redirect together, then redirect alone.
    cycle(1'b1, 1'b1, 32'h3204);
    cycle(1'b0, 1'b1, 32'h3204);
    // Unaligned target and targets outside the IM window (address wrap).
    cycle(1'b0, 1'b1, 32'h3333);
    cycle(1'b0, 1'b1, 32'h0000_0010);
    cycle(1'b0, 1'b1, 32'h0000_7008);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      logic s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 1) == 1) ? (32'h3000 + $urandom_range(0, 32'h5000)) : $urandom;
      cycle(s, r, t);
    end

    // Mid-run reset with stall asserted: state clears without an edge, no bubble.
    stall = 1'b1; D_redirect = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_vals();
    @(posedge clk); #1;
    check_reset_vals();
    stall = 1'b0; D_redirect = 1'b0;
    #1 reset = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    repeat (5) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h3400);
    cycle(1'b0, 1'b1, 32'h3000);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);

    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
